// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: valid/ready FIFO built on a 64x16 single-port RAM
// Optional macro SPFIFO_WR_PRIO_EN: writes always win RAM conflicts
module spram_fifo_ctrl #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

`ifndef SPFIFO_WR_PRIO_EN
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_t;

    prio_t prio_q;
    prio_t prio_d;
`endif

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] a_q;
    logic [AW:0]   used_q;
    logic [AW:0]   unread_q;
    logic [AW:0]   used_d;
    logic [AW:0]   unread_d;
    logic          inflight_q;
    logic [1:0]    obuf_cnt_q;
    logic [1:0]    obuf_cnt_d;
    logic          obuf_hd_q;
    logic          obuf_tl;
    logic [DW-1:0] obuf_q [2];

    logic ram_full;
    logic wr_want;
    logic rd_want;
    logic wr_gnt;
    logic rd_gnt;
    logic cap;
    logic pop;

    // Requests depend on registered state only, never on grants
    assign ram_full = (used_q == FULL);
    assign wr_want  = in_valid && !ram_full;
    assign rd_want  = (unread_q != '0) &&
                      ((obuf_cnt_q + 2'(inflight_q)) < 2'd2);

`ifdef SPFIFO_WR_PRIO_EN
    // Writes win every conflict; reads fill idle cycles
    always_comb begin
        wr_gnt   = wr_want;
        rd_gnt   = rd_want && !wr_want;
        in_ready = !ram_full;
    end
`else
    // Round-robin between push and prefetch, flipping only on conflict
    always_comb begin
        wr_gnt   = wr_want && (!rd_want || (prio_q == PRIO_WR));
        rd_gnt   = rd_want && (!wr_want || (prio_q == PRIO_RD));
        in_ready = !ram_full && !(rd_want && (prio_q == PRIO_RD));
        prio_d   = prio_q;
        if (wr_want && rd_want) begin
            prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
        end
    end

    // Arbitration priority register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= PRIO_WR;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // RAM port: address follows the grant, otherwise holds
    always_comb begin
        ram_a = a_q;
        unique case (1'b1)
            wr_gnt:  ram_a = wr_ptr_q;
            rd_gnt:  ram_a = rd_ptr_q;
            default: ram_a = a_q;
        endcase
    end

    assign ram_we = wr_gnt && rst_n;
    assign ram_di = in_data;

    // A read's data lands one cycle after its grant
    assign cap       = inflight_q;
    assign out_valid = (obuf_cnt_q != 2'd0);
    assign out_data  = obuf_q[obuf_hd_q];
    assign pop       = out_valid && out_ready;
    assign obuf_tl   = obuf_hd_q ^ obuf_cnt_q[0];

    // Next occupancy; a RAM slot is released only at capture
    always_comb begin
        used_d     = used_q + (AW + 1)'(wr_gnt) - (AW + 1)'(cap);
        unread_d   = unread_q + (AW + 1)'(wr_gnt) - (AW + 1)'(rd_gnt);
        obuf_cnt_d = obuf_cnt_q + 2'(cap) - 2'(pop);
    end

    assign count = used_q + (AW + 1)'(obuf_cnt_q);

    // Pointers, occupancy and read tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            a_q        <= '0;
            used_q     <= '0;
            unread_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            if (wr_gnt) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_gnt) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            a_q        <= ram_a;
            used_q     <= used_d;
            unread_q   <= unread_d;
            inflight_q <= rd_gnt;
        end
    end

    // Two-entry output buffer; capture and pop may coincide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
            obuf_hd_q  <= 1'b0;
            obuf_cnt_q <= 2'd0;
        end else begin
            if (cap) begin
                obuf_q[obuf_tl] <= ram_do;
            end
            if (pop) begin
                obuf_hd_q <= ~obuf_hd_q;
            end
            obuf_cnt_q <= obuf_cnt_d;
        end
    end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb_spram_fifo_ctrl: vector table, corner sequences and random run
// against a queue model of the FIFO and a behavioural RAM
module tb_spram_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    always #5 clk = ~clk;

    spram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    logic [DW-1:0] mem [64];

    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
        ram_do <= mem[ram_a];
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] q [$];
    int wr_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_cycle();
        if (!rst_n) begin
            chk("rst_we", 32'(ram_we), 0);
            q.delete();
            wr_cnt = 0;
        end else begin
            chk("count", 32'(count), q.size());
            chk("cnt_max", 32'(count <= 7'd66), 1);
            if (q.size() == 0) chk("empty_ov", 32'(out_valid), 0);
            else if (out_valid) chk("data", 32'(out_data), 32'(q[0]));
            chk("we_hs", 32'(ram_we), 32'(in_valid && in_ready));
            if (ram_we) begin
                chk("wr_addr", 32'(ram_a), wr_cnt % 64);
                chk("wr_di", 32'(ram_di), 32'(in_data));
            end
            if (out_valid && out_ready && q.size() > 0)
                void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(in_data);
            if (ram_we) wr_cnt++;
        end
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && count != 0; i++) step();
        chk("drain", 32'(count), 0);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic [5:0]  m;
        logic        we;
        logic [5:0]  a;
        logic        ir;
        logic        ov;
        logic [15:0] od;
        logic [6:0]  cnt;
    } vec_t;

    localparam logic [5:0] M_WE = 6'b100000;
    localparam logic [5:0] M_A  = 6'b010000;
    localparam logic [5:0] M_IR = 6'b001000;
    localparam logic [5:0] M_OV = 6'b000100;
    localparam logic [5:0] M_OD = 6'b000010;
    localparam logic [5:0] M_CT = 6'b000001;

    function automatic vec_t mk(logic iv, logic [15:0] id, logic ordy,
                                logic [5:0] m, logic we, logic [5:0] a,
                                logic ir, logic ov, logic [15:0] od,
                                logic [6:0] cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.m = m;
        v.we = we; v.a = a; v.ir = ir; v.ov = ov;
        v.od = od; v.cnt = cnt;
        return v;
    endfunction

    vec_t tv [11];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic hs;
        logic seen;
        logic prev_we;
        int nxt;
        int nw;
        int alt_bad;

        tv[0]  = mk(1, 16'h1234, 0, M_WE|M_A|M_IR|M_OV|M_CT,
                    1, 0, 1, 0, 0, 0);
        tv[1]  = mk(0, 16'h0000, 0, M_WE|M_A|M_IR|M_OV|M_CT,
                    0, 0, 1, 0, 0, 1);
        tv[2]  = mk(0, 16'h0000, 0, M_WE|M_A|M_OV|M_CT,
                    0, 0, 0, 0, 0, 1);
        tv[3]  = mk(0, 16'h0000, 1, M_WE|M_OV|M_OD|M_CT,
                    0, 0, 0, 1, 16'h1234, 1);
        tv[4]  = mk(1, 16'hAAAA, 0, M_WE|M_A|M_IR|M_OV|M_CT,
                    1, 1, 1, 0, 0, 0);
        tv[5]  = mk(1, 16'hBBBB, 0, M_WE|M_A|M_IR|M_CT,
                    1, 2, 1, 0, 0, 1);
        tv[6]  = mk(0, 16'h0000, 0, M_WE|M_A|M_OV|M_CT,
                    0, 1, 0, 0, 0, 2);
        tv[7]  = mk(0, 16'h0000, 0, M_WE|M_A|M_OV|M_CT,
                    0, 2, 0, 0, 0, 2);
        tv[8]  = mk(0, 16'h0000, 1, M_WE|M_A|M_OV|M_OD|M_CT,
                    0, 2, 0, 1, 16'hAAAA, 2);
        tv[9]  = mk(0, 16'h0000, 1, M_OV|M_OD|M_CT,
                    0, 0, 0, 1, 16'hBBBB, 1);
        tv[10] = mk(0, 16'h0000, 0, M_WE|M_OV|M_CT,
                    0, 0, 0, 0, 0, 0);

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        step();
        do_reset();

        #1;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_cnt", 32'(count), 0);
        model_cycle();
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            in_valid  = tv[i].iv;
            in_data   = tv[i].id;
            out_ready = tv[i].ordy;
            #1;
            if (tv[i].m[5])
                chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(tv[i].we));
            if (tv[i].m[4])
                chk($sformatf("v%0d_a", i), 32'(ram_a), 32'(tv[i].a));
            if (tv[i].m[3])
                chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(tv[i].ir));
            if (tv[i].m[2])
                chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tv[i].ov));
            if (tv[i].m[1])
                chk($sformatf("v%0d_od", i), 32'(out_data), 32'(tv[i].od));
            if (tv[i].m[0])
                chk($sformatf("v%0d_cnt", i), 32'(count), 32'(tv[i].cnt));
            model_cycle();
            @(negedge clk);
        end

        nxt = 16'h0100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nw = 0;
        alt_bad = 0;
        prev_we = 1'b0;
        for (int i = 0; i < 26; i++) begin
            in_data = 16'(nxt);
            #1;
            hs = in_valid && in_ready;
            if (i >= 6) begin
                if (ram_we) nw++;
                if (i > 6 && ram_we == prev_we) alt_bad++;
            end
            prev_we = ram_we;
            model_cycle();
            @(negedge clk);
            if (hs) nxt++;
        end
`ifdef SPFIFO_WR_PRIO_EN
        chk("stream_writes", nw, 20);
        chk("stream_no_rd", 32'(out_valid), 0);
`else
        chk("stream_writes", nw, 10);
        chk("stream_alt", alt_bad, 0);
`endif
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (out_valid) seen = 1'b1;
            model_cycle();
            @(negedge clk);
        end
        chk("stream_ov", 32'(seen), 1);
        drain();

        in_valid = 1'b1;
        in_data  = 16'h5555;
        step();
        in_valid = 1'b0;
        #1;
        chk("mid_rd_we", 32'(ram_we), 0);
        model_cycle();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h6666;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mrst_ov", 32'(out_valid), 0);
        chk("mrst_cnt", 32'(count), 0);
        chk("mrst_we", 32'(ram_we), 0);
        chk("mrst_od", 32'(out_data), 0);
        model_cycle();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        #1;
        chk("mrst_push_we", 32'(ram_we), 1);
        chk("mrst_push_a", 32'(ram_a), 0);
        model_cycle();
        @(negedge clk);
        drain();

        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nxt = 0;
        for (int i = 0; i < 400 && count != 7'd66; i++) begin
            in_data = 16'(nxt);
            #1;
            hs = in_valid && in_ready;
            model_cycle();
            @(negedge clk);
            if (hs) nxt++;
        end
        chk("fill_cnt", 32'(count), 66);
        chk("fill_pushed", nxt, 66);
        in_data = 16'h0042;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_ir", 32'(in_ready), 0);
            model_cycle();
            @(negedge clk);
        end
        #1;
        chk("full_head", 32'(out_data), 0);
        out_ready = 1'b1;
        model_cycle();
        @(negedge clk);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            #1;
            if (in_ready) seen = 1'b1;
            model_cycle();
            @(negedge clk);
        end
        chk("refill_ir", 32'(seen), 1);
        drain();

        do_reset();
        nxt = 0;
        for (int i = 0; i < 3000 && !(nxt == 200 && count == 0); i++) begin
            in_valid  = (nxt < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 16'(nxt);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            hs = in_valid && in_ready;
            model_cycle();
            @(negedge clk);
            if (hs) nxt++;
        end
        chk("rand_pushed", nxt, 200);
        chk("rand_empty", 32'(count), 0);
        chk("rand_wraps", wr_cnt, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
